ethernet_mac_decap: RTL and testbench

MAC receive-side frame decapsulation for the tri-mode (10/100/1000) MAC.
- Accepts GMII receive bytes and detects preamble/SFD.
- Strips preamble, SFD and FCS, and checks CRC-32 and frame length.
- Emits destination address through payload as a byte-wide AXI-Stream master, with no backpressure.
- Sits between the GMII/PHY receive pins and the RX FIFO.

---
 rtl/ethernet_mac_decap.sv | 156 +++++++++++++++
 tb/tb_ethernet_mac_decap.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_mac_decap.sv
// GMII receive decapsulation: strips preamble/SFD/FCS, checks CRC-32 and length, emits byte AXI-Stream.
// Define ETH_RX_STATS_EN to add saturating rx_good_count / rx_bad_count frame counters.
module ethernet_mac_decap #(
  parameter int MIN_PAYLOAD_LENGTH = 46,
  parameter int MAX_PAYLOAD_LENGTH = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        tuser
`ifdef ETH_RX_STATS_EN
  ,
  output logic [31:0] rx_good_count,
  output logic [31:0] rx_bad_count
`endif
);

  // state     | meaning
  // WAIT_IDLE | wait for rxdv low so we never lock on mid-frame
  // IDLE      | hunting for preamble or SFD
  // PREAMBLE  | inside a run of 0x55
  // DATA      | frame bytes; last four held back so the FCS never reaches tdata
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA} state_t;

  localparam int MIN_FRAME_LENGTH = MIN_PAYLOAD_LENGTH + 14;
  localparam int MAX_FRAME_LENGTH = MAX_PAYLOAD_LENGTH + 14;
  localparam int LW = $clog2(MAX_FRAME_LENGTH + 6);
  localparam logic [LW-1:0] LEN_SAT  = LW'(MAX_FRAME_LENGTH + 5);
  localparam logic [LW-1:0] LEN_MIN  = LW'(MIN_FRAME_LENGTH + 4);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_FRAME_LENGTH + 4);
  localparam logic [LW-1:0] LEN_DLY  = LW'(4);
  localparam logic [LW-1:0] LEN_HOLD = LW'(5);
  localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB20E3;

  state_t          state;
  logic [LW-1:0]   len;
  logic [31:0]     crc;
  logic [3:0][7:0] dly;
  logic [7:0]      hold;
  logic            err;
  logic            frame_bad;
  logic            sfd_seen;
`ifdef ETH_RX_STATS_EN
  logic            runt_drop;
`endif

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign frame_bad = (crc != CRC_RESIDUE) | err | gmii_rxer | (len < LEN_MIN) | (len > LEN_MAX);
  assign sfd_seen  = (state == IDLE || state == PREAMBLE) && gmii_rxdv && (gmii_rxd == 8'hD5);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= WAIT_IDLE;
      len    <= '0;
      crc    <= '1;
      dly    <= '0;
      hold   <= '0;
      err    <= 1'b0;
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
`ifdef ETH_RX_STATS_EN
      runt_drop <= 1'b0;
`endif
    end else begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
`ifdef ETH_RX_STATS_EN
      runt_drop <= 1'b0;
`endif
      if (clk_enable) begin
        if (sfd_seen) begin
          state <= DATA;
          crc   <= '1;
          len   <= '0;
          err   <= 1'b0;
          hold  <= '0;
        end else begin
          case (state)
            WAIT_IDLE: if (!gmii_rxdv) state <= IDLE;
            IDLE:      if (gmii_rxdv) state <= (gmii_rxd == 8'h55) ? PREAMBLE : WAIT_IDLE;
            PREAMBLE: begin
              if (!gmii_rxdv)              state <= IDLE;
              else if (gmii_rxd != 8'h55)  state <= WAIT_IDLE;
            end
            DATA: begin
              if (gmii_rxdv) begin
                err <= err | gmii_rxer;
                crc <= crc_byte(crc, gmii_rxd);
                dly <= {dly[2:0], gmii_rxd};
                if (len == LEN_SAT - LW'(1)) begin
                  // oversize: close the frame as bad and ignore the rest of the burst
                  len    <= LEN_SAT;
                  tdata  <= hold;
                  tvalid <= 1'b1;
                  tlast  <= 1'b1;
                  tuser  <= 1'b1;
                  state  <= WAIT_IDLE;
                end else begin
                  len <= len + LW'(1);
                  if (len >= LEN_DLY) hold <= dly[3];
                  if (len >= LEN_HOLD) begin
                    tdata  <= hold;
                    tvalid <= 1'b1;
                  end
                end
              end else begin
                state <= IDLE;
                if (len >= LEN_HOLD) begin
                  tdata  <= hold;
                  tvalid <= 1'b1;
                  tlast  <= 1'b1;
                  tuser  <= frame_bad;
                end
`ifdef ETH_RX_STATS_EN
                else runt_drop <= 1'b1;
`endif
              end
            end
            default: state <= WAIT_IDLE;
          endcase
        end
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_good_count <= '0;
      rx_bad_count  <= '0;
    end else begin
      if (tvalid && tlast && !tuser && rx_good_count != '1)
        rx_good_count <= rx_good_count + 32'd1;
      if (((tvalid && tlast && tuser) || runt_drop) && rx_bad_count != '1)
        rx_bad_count <= rx_bad_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ethernet_mac_decap.sv
// Scoreboard bench for ethernet_mac_decap: directed GMII frames, expected beats queued at issue time.
module tb_ethernet_mac_decap;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic [7:0] gmii_rxd;
  logic       gmii_rxdv;
  logic       gmii_rxer;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
`ifdef ETH_RX_STATS_EN
  logic [31:0] rx_good_count;
  logic [31:0] rx_bad_count;
`endif

  ethernet_mac_decap dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .gmii_rxd   (gmii_rxd),
    .gmii_rxdv  (gmii_rxdv),
    .gmii_rxer  (gmii_rxer),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tlast      (tlast),
    .tuser      (tuser)
`ifdef ETH_RX_STATS_EN
    ,
    .rx_good_count (rx_good_count),
    .rx_bad_count  (rx_bad_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         en_div = 1;
  logic       lat_chk = 1'b0;
  logic       lat_pending = 1'b0;
  int         first_sample_cyc = -1;
  logic       space_chk = 1'b0;
  int         prev_beat_cyc = -1;
  logic [7:0] body [0:1599];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every beat the DUT presents is popped against the scoreboard
  always @(negedge clk) begin : monitor
    beat_t e;
    if (reset && tvalid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got data=%02h last=%0b user=%0b, none expected", tdata, tlast, tuser);
      end else begin
        e = exp_q.pop_front();
        if (tdata !== e.d || tlast !== e.last || (e.last && tuser !== e.user)) begin
          fails++;
          $display("FAIL beat: got data=%02h last=%0b user=%0b, expected data=%02h last=%0b user=%0b",
                   tdata, tlast, tuser, e.d, e.last, e.user);
        end
      end
      if (lat_pending) begin
        lat_pending = 1'b0;
        tests++;
        if (cyc - first_sample_cyc != 5) begin
          fails++;
          $display("FAIL first_beat_latency: got %0d edges after byte 1 sample, expected 5", cyc - first_sample_cyc);
        end
      end
      if (space_chk && prev_beat_cyc >= 0) begin
        tests++;
        if (cyc - prev_beat_cyc != en_div) begin
          fails++;
          $display("FAIL beat_spacing: got %0d cycles, expected %0d", cyc - prev_beat_cyc, en_div);
        end
      end
      prev_beat_cyc = tlast ? -1 : cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    for (int i = 0; i < en_div - 1; i++) begin
      clk_enable = 1'b0;
      @(posedge clk); #1;
    end
    clk_enable = 1'b1;
    gmii_rxd   = d;
    gmii_rxdv  = dv;
    gmii_rxer  = er;
    @(posedge clk); #1;
  endtask

  // fcs_flip/er_idx/rst_idx < 0 disable the corresponding fault; n_exp beats are queued
  task automatic send_frame(input int n_body, input int fcs_flip, input int er_idx, input int rst_idx,
                            input int n_exp, input logic exp_last, input logic exp_bad, input int seed);
    logic [31:0] c;
    logic [7:0]  fb;
    beat_t       b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_body; i++) begin
      body[i] = 8'(i * 13 + seed);
      c = c ^ {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < n_exp; i++) begin
      b.d    = body[i];
      b.last = exp_last && (i == n_exp - 1);
      b.user = exp_bad;
      exp_q.push_back(b);
    end
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n_body; i++) begin
      if (rst_idx >= 0 && i == rst_idx) begin
        @(negedge clk); #1;
        reset = 1'b0;
      end
      if (rst_idx >= 0 && i == rst_idx + 3) reset = 1'b1;
      if (i == 0 && lat_chk) begin
        first_sample_cyc = cyc + 1;
        lat_pending = 1'b1;
      end
      drive(body[i], 1'b1, i == er_idx);
      if (rst_idx >= 0 && i == rst_idx + 1) begin
        tests++;
        if (tvalid !== 1'b0 || tdata !== 8'h00 || tlast !== 1'b0) begin
          fails++;
          $display("FAIL reset_clears_outputs: got tvalid=%0b tdata=%02h tlast=%0b, expected 0/00/0", tvalid, tdata, tlast);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      fb = c[8*k +: 8];
      if (k == fcs_flip) fb = fb ^ 8'h01;
      drive(fb, 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

`ifdef ETH_RX_STATS_EN
  task automatic check_stats(input int g, input int bd);
    tests++;
    if (rx_good_count !== 32'(g) || rx_bad_count !== 32'(bd)) begin
      fails++;
      $display("FAIL stats: got good=%0d bad=%0d, expected good=%0d bad=%0d", rx_good_count, rx_bad_count, g, bd);
    end
  endtask
`endif

  initial begin
    reset      = 1'b0;
    clk_enable = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rxdv  = 1'b0;
    gmii_rxer  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (tvalid !== 1'b0 || tdata !== 8'h00 || tlast !== 1'b0 || tuser !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got tvalid=%0b tdata=%02h tlast=%0b tuser=%0b, expected all 0", tvalid, tdata, tlast, tuser);
    end
`ifdef ETH_RX_STATS_EN
    check_stats(0, 0);
`endif
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);

    lat_chk = 1'b1;
    send_frame(60, -1, -1, -1, 60, 1'b1, 1'b0, 8'h11);   // good 64-byte frame
    lat_chk = 1'b0;
`ifdef ETH_RX_STATS_EN
    check_stats(1, 0);
`endif
    send_frame(60, 1, -1, -1, 60, 1'b1, 1'b1, 8'h11);    // FCS byte 2 corrupted
`ifdef ETH_RX_STATS_EN
    check_stats(1, 1);
`endif
    send_frame(36, -1, -1, -1, 36, 1'b1, 1'b1, 8'h22);   // runt, L=40
`ifdef ETH_RX_STATS_EN
    check_stats(1, 2);
`endif
    send_frame(1600, -1, -1, -1, 1514, 1'b1, 1'b1, 8'h33); // oversize burst
`ifdef ETH_RX_STATS_EN
    check_stats(1, 3);
`endif
    send_frame(60, -1, -1, -1, 60, 1'b1, 1'b0, 8'h44);   // recovery after oversize
`ifdef ETH_RX_STATS_EN
    check_stats(2, 3);
`endif
    send_frame(60, -1, 19, -1, 60, 1'b1, 1'b1, 8'h55);   // rxer on byte 20
`ifdef ETH_RX_STATS_EN
    check_stats(2, 4);
`endif
    en_div = 10;
    space_chk = 1'b1;
    send_frame(60, -1, -1, -1, 60, 1'b1, 1'b0, 8'h55);   // 100M strobe rate
    space_chk = 1'b0;
    en_div = 1;
`ifdef ETH_RX_STATS_EN
    check_stats(3, 4);
`endif
    // reset before byte 31: bytes 1..25 already emitted, nothing after
    send_frame(60, -1, -1, 30, 25, 1'b0, 1'b0, 8'h66);
`ifdef ETH_RX_STATS_EN
    check_stats(0, 0);
`endif
    send_frame(60, -1, -1, -1, 60, 1'b1, 1'b0, 8'h77);
`ifdef ETH_RX_STATS_EN
    check_stats(1, 0);
`endif
    for (int i = 0; i < 20; i++) drive(8'h00, 1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d beats still expected, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
